// File: rtl/finv_arbiter.sv
// Round-robin arbiter sharing one fixed-latency finv pipeline between N_REQ requesters.
// A shadow tag pipeline aligned with finv_y routes each result back to its issuer.
module finv_arbiter #(
  parameter int N_REQ   = 4,
  parameter int LATENCY = 3,
  parameter int TAG_W   = 2
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [N_REQ-1:0]             req_valid,
  input  logic [32*N_REQ-1:0]          req_x,
  output logic [N_REQ-1:0]             req_ready,
  output logic [N_REQ-1:0]             resp_valid,
  output logic [31:0]                  resp_y,
  output logic [31:0]                  finv_x,
  input  logic [31:0]                  finv_y,
  output logic [N_REQ-1:0]             busy,
  output logic [$clog2(N_REQ+1)-1:0]   inflight
);

  localparam int CNT_W = $clog2(N_REQ+1);

  logic [TAG_W-1:0] ptr;
  logic [N_REQ-1:0] eligible;
  logic             grant_any;
  logic [TAG_W-1:0] winner;
  logic [TAG_W-1:0] ptr_next;
  int               idx;

  logic             vld_p [LATENCY];
  logic [TAG_W-1:0] tag_p [LATENCY];
  logic             resp_any;

  // Arbitration: scan upward from ptr with wrap; reset forces the grant off.
  always_comb begin
    eligible  = req_valid & ~busy;
    grant_any = 1'b0;
    winner    = '0;
    idx       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!grant_any && rstn && eligible[idx]) begin
        grant_any = 1'b1;
        winner    = TAG_W'(idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    finv_x    = '0;
    if (grant_any) begin
      req_ready = N_REQ'(1) << winner;
      finv_x    = req_x[int'(winner)*32 +: 32];
    end
  end

  always_comb begin
    if (int'(winner) == N_REQ-1) ptr_next = '0;
    else                         ptr_next = winner + TAG_W'(1);
  end

  // Response stage: last tag stage is aligned with finv_y.
  always_comb begin
    resp_any   = vld_p[LATENCY-1];
    resp_valid = '0;
    resp_y     = '0;
    if (resp_any) begin
      resp_valid = N_REQ'(1) << tag_p[LATENCY-1];
      resp_y     = finv_y;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr      <= '0;
      busy     <= '0;
      inflight <= '0;
      for (int s = 0; s < LATENCY; s++) vld_p[s] <= 1'b0;
    end else begin
      if (grant_any) ptr <= ptr_next;
      busy <= (busy | req_ready) & ~resp_valid;
      case ({grant_any, resp_any})
        2'b10:   inflight <= inflight + CNT_W'(1);
        2'b01:   inflight <= inflight - CNT_W'(1);
        default: inflight <= inflight;
      endcase
      vld_p[0] <= grant_any;
      for (int s = 1; s < LATENCY; s++) vld_p[s] <= vld_p[s-1];
    end
  end

  // Tag payload needs no reset: it is only observed when its vld bit is set.
  always_ff @(posedge clk) begin
    tag_p[0] <= winner;
    for (int s = 1; s < LATENCY; s++) tag_p[s] <= tag_p[s-1];
  end

endmodule

// File: tb/tb_finv_arbiter.sv
// Directed bench for finv_arbiter using a 3-stage inverting stub as the finv unit.
module tb_finv_arbiter;

  logic         clk;
  logic         rstn;
  logic [3:0]   req_valid;
  logic [127:0] req_x;
  logic [3:0]   req_ready;
  logic [3:0]   resp_valid;
  logic [31:0]  resp_y;
  logic [31:0]  finv_x;
  logic [31:0]  finv_y;
  logic [3:0]   busy;
  logic [2:0]   inflight;

  logic [31:0]  s0, s1, s2;

  int n_chk = 0;
  int n_err = 0;

  finv_arbiter #(.N_REQ(4), .LATENCY(3), .TAG_W(2)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_x(req_x),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_y(resp_y),
    .finv_x(finv_x), .finv_y(finv_y), .busy(busy), .inflight(inflight)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // No-reset stub pipeline: y = ~x, three registers deep.
  always @(posedge clk) begin
    s0 <= finv_x;
    s1 <= s0;
    s2 <= s1;
  end
  assign finv_y = s2 ^ 32'hFFFFFFFF;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [3:0] v, input logic [31:0] x0, input logic [31:0] x1,
                         input logic [31:0] x2, input logic [31:0] x3);
    req_valid = v;
    req_x     = {x3, x2, x1, x0};
  endtask

  // Reset with all requests asserted: grants must still be suppressed.
  task automatic do_reset();
    next();
    rstn = 1'b0;
    set_req(4'hF, 32'h11, 32'h22, 32'h33, 32'h44);
    #1;
    check("rst_ready", req_ready, 0);
    check("rst_resp", resp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_inflight", inflight, 0);
    check("rst_finv_x", finv_x, 0);
    next();
    set_req(4'h0, 0, 0, 0, 0);
    rstn = 1'b1;
  endtask

  initial begin
    rstn = 1'b0;
    set_req(4'h0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);

    // Single op
    do_reset();
    set_req(4'b0001, 32'h40000000, 0, 0, 0);
    #1;
    check("t1_ready", req_ready, 4'b0001);
    check("t1_finv_x", finv_x, 32'h40000000);
    next();
    set_req(4'h0, 0, 0, 0, 0);
    #1;
    check("t1_busy", busy, 4'b0001);
    check("t1_inflight", inflight, 1);
    check("t1_ready_idle", req_ready, 0);
    next(); #1;
    check("t1_noresp", resp_valid, 0);
    next(); #1;
    check("t1_resp", resp_valid, 4'b0001);
    check("t1_resp_y", resp_y, 32'hBFFFFFFF);
    next(); #1;
    check("t1_busy_clr", busy, 0);
    check("t1_resp_clr", resp_valid, 0);
    check("t1_inflight0", inflight, 0);

    // All four requesters
    do_reset();
    set_req(4'b1111, 1, 2, 3, 4);
    #1;
    check("t2_g0", req_ready, 4'b0001);
    check("t2_x0", finv_x, 1);
    next(); #1;
    check("t2_g1", req_ready, 4'b0010);
    check("t2_x1", finv_x, 2);
    check("t2_inf1", inflight, 1);
    next(); #1;
    check("t2_g2", req_ready, 4'b0100);
    check("t2_inf2", inflight, 2);
    next(); #1;
    check("t2_g3", req_ready, 4'b1000);
    check("t2_inf3", inflight, 3);
    check("t2_r0", resp_valid, 4'b0001);
    check("t2_y0", resp_y, 32'hFFFFFFFE);
    next(); #1;
    check("t2_regrant0", req_ready, 4'b0001);
    check("t2_inf_hold", inflight, 3);
    check("t2_r1", resp_valid, 4'b0010);
    check("t2_y1", resp_y, 32'hFFFFFFFD);
    next();
    set_req(4'h0, 0, 0, 0, 0);
    #1;
    check("t2_r2", resp_valid, 4'b0100);
    check("t2_y2", resp_y, 32'hFFFFFFFC);
    check("t2_inf_a", inflight, 3);
    next(); #1;
    check("t2_r3", resp_valid, 4'b1000);
    check("t2_y3", resp_y, 32'hFFFFFFFB);
    check("t2_inf_b", inflight, 2);
    next(); #1;
    check("t2_r0b", resp_valid, 4'b0001);
    check("t2_y0b", resp_y, 32'hFFFFFFFE);
    next(); #1;
    check("t2_inf_end", inflight, 0);
    check("t2_busy_end", busy, 0);

    // Round-robin fairness with pointer at 2
    do_reset();
    set_req(4'b0010, 0, 32'hB1, 0, 0);
    #1;
    check("t3_g1", req_ready, 4'b0010);
    next();
    set_req(4'b1001, 32'hA0, 0, 0, 32'hA3);
    #1;
    check("t3_g3", req_ready, 4'b1000);
    check("t3_x3", finv_x, 32'hA3);
    next();
    set_req(4'b0001, 32'hA0, 0, 0, 0);
    #1;
    check("t3_g0", req_ready, 4'b0001);
    check("t3_x0", finv_x, 32'hA0);
    next();
    set_req(4'h0, 0, 0, 0, 0);
    repeat (4) next();

    // Back-to-back same requester
    do_reset();
    set_req(4'b0010, 0, 32'h55, 0, 0);
    for (int k = 0; k < 9; k++) begin
      if (k > 0) next();
      #1;
      check($sformatf("t4_ready_%0d", k), req_ready, (k % 4 == 0) ? 4'b0010 : 4'b0000);
      check($sformatf("t4_busy_%0d", k), busy[1], (k % 4 != 0) ? 1'b1 : 1'b0);
    end
    next();
    set_req(4'h0, 0, 0, 0, 0);
    repeat (4) next();

    // Reset mid-flight
    do_reset();
    set_req(4'b0100, 0, 0, 32'h12345678, 0);
    #1;
    check("t5_g2", req_ready, 4'b0100);
    next();
    set_req(4'h0, 0, 0, 0, 0);
    rstn = 1'b0;
    #1;
    check("t5_busy_rst", busy, 0);
    check("t5_resp_rst", resp_valid, 0);
    check("t5_inf_rst", inflight, 0);
    next();
    rstn = 1'b1;
    #1;
    check("t5_resp_a", resp_valid, 0);
    check("t5_busy_a", busy, 0);
    next(); #1;
    check("t5_stale_y", finv_y, 32'hEDCBA987);
    check("t5_resp_b", resp_valid, 0);
    check("t5_resp_y", resp_y, 0);
    next(); #1;
    check("t5_resp_c", resp_valid, 0);

    // Idle with pointer left at 2
    do_reset();
    set_req(4'b0010, 0, 32'h77, 0, 0);
    #1;
    check("t6_g1", req_ready, 4'b0010);
    next();
    set_req(4'h0, 0, 0, 0, 0);
    repeat (2) next();
    #1;
    check("t6_resp", resp_valid, 4'b0010);
    check("t6_resp_y", resp_y, 32'hFFFFFF88);
    for (int k = 0; k < 10; k++) begin
      next(); #1;
      check($sformatf("t6_idle_ready_%0d", k), req_ready, 0);
      check($sformatf("t6_idle_resp_%0d", k), resp_valid, 0);
      check($sformatf("t6_idle_x_%0d", k), finv_x, 0);
    end
    next();
    set_req(4'b1001, 32'hC0, 0, 0, 32'hC3);
    #1;
    check("t6_ptr_kept", req_ready, 4'b1000);
    check("t6_ptr_x", finv_x, 32'hC3);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/finv_arbiter.md
Name: finv_arbiter

Overview:
- Shares one fixed-latency reciprocal pipeline (finv: 32-bit float in, 32-bit float out, no stall, no reset) between N_REQ requesters.
- Arbitration is round-robin. Each granted operation carries a tag through a shadow pipeline, so the result returns to the requester that issued it.
- Sits between the FPU issue logic and the finv unit. Each requester has at most one operation outstanding.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- LATENCY, 3, cycles from acceptance to result. Equals the finv register depth: operand sampled at the end of cycle t, y valid in cycle t+3.
- TAG_W, 2, tag width; must satisfy 2**TAG_W >= N_REQ.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- req_valid  in  N_REQ  operand valid, one bit per requester.
- req_x  in  32*N_REQ  operands; requester i uses bits [32i+31:32i].
- req_ready  out  N_REQ  one-hot grant; handshake completes when valid&ready.
- resp_valid  out  N_REQ  one-cycle result pulse to the owning requester.
- resp_y  out  32  shared result bus; valid only while a resp_valid bit is high.
- finv_x  out  32  operand to the finv pipeline.
- finv_y  in  32  result from the finv pipeline.
- busy  out  N_REQ  requester has an operation in flight.
- inflight  out  $clog2(N_REQ+1)  number of operations in the pipeline.

Behaviour:
- Reset (async, rstn=0):
  - busy=0, tag pipe valids=0, priority pointer=0, inflight=0.
  - req_ready=0 and resp_valid=0 immediately (combinational from cleared state).
  - finv_x=0.
- Eligibility: eligible[i] = req_valid[i] & ~busy[i].
- Arbitration (combinational, once per cycle):
  - Scan from the pointer upward with wrap-around; the first eligible index wins.
  - req_ready = one-hot(winner), or 0 if no requester is eligible.
  - req_ready may depend on req_valid. Requesters must not make req_valid depend on req_ready.
- Pointer: on a grant to i, the pointer becomes (i+1) mod N_REQ at the clock edge. With no grant it holds.
- finv_x:
  - Equals req_x of the winner in the grant cycle.
  - Otherwise 0. The finv output for an idle cycle is ignored.
- Tag pipe:
  - LATENCY-deep shift register of {vld, tag}.
  - Stage 0 loads {grant_any, winner} every edge.
  - The last stage is aligned with finv_y, so the tag granted in cycle t appears at the output in cycle t+LATENCY.
- Response (combinational from the last stage):
  - resp_valid[tag] = vld; resp_y = finv_y when vld, else 0.
  - At most one response per cycle.
- busy[i]:
  - Set at the edge ending the grant cycle.
  - Cleared at the edge ending i's response cycle.
  - Earliest re-grant to the same requester is cycle t+LATENCY+1.
  - Set and clear of the same bit never coincide, because of one outstanding op per requester.
- inflight:
  - +1 on grant, -1 on response, unchanged when both occur in the same cycle.
  - Never exceeds N_REQ.
- Throughput: one acceptance per cycle whenever any requester is eligible. With N_REQ >= LATENCY+1 and all requesters valid, the pipeline stays full.
- Reset mid-operation:
  - All in-flight tags are dropped and no resp_valid is produced for them.
  - Stale finv_y data after reset is never forwarded because the vld bits are 0.
- req_valid deasserted without a handshake: no effect; no state changes.

Test Plan:
The bench uses a 3-stage no-reset stub, y = x ^ 32'hFFFFFFFF, to check routing.
- Single op: reset, then req0 x=32'h40000000 for one cycle (t=2). Expect req_ready=4'b0001 at t=2, busy[0]=1 from t=3, resp_valid=4'b0001 with resp_y=32'hBFFFFFFF at t=5, busy[0]=0 at t=6.
- All four requesters valid from t=2 with x=i+1. Expect:
  - Grants at 2,3,4,5 to 0,1,2,3.
  - Responses at 5,6,7,8 with y=~(i+1).
  - inflight peaks at 3.
  - Requester 0 re-granted at t=6 if it is still valid.
- Round-robin fairness: with the pointer at 2, req0 and req3 both valid. Expect grant 3 first, then 0.
- Back-to-back same requester: req1 held valid continuously. Expect grants at t, t+4, t+8; no grant while busy[1]=1.
- Reset mid-flight: grant req2 at t=2, assert rstn=0 at t=3 for one cycle. Expect:
  - busy=0 and resp_valid=0 throughout.
  - No response at t=5, although the stub's finv_y is still non-zero.
- Idle: no req_valid for 10 cycles. Expect req_ready=0, resp_valid=0, finv_x=0, and the pointer unchanged.
